// File: rtl/hash_pkg.sv
// Shared types and width helpers for the hash table request path.
package hash_pkg;

  localparam int HP_DATA_WIDTH = 64;
  localparam int HP_NUM_REQ    = 4;

  function automatic int keep_w(input int dw);
    return dw / 8;
  endfunction

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

  // Default-configuration beat layout, shared with the response router.
  typedef struct packed {
    logic [HP_DATA_WIDTH-1:0]         data;
    logic [keep_w(HP_DATA_WIDTH)-1:0] keep;
    logic                             last;
    logic [id_w(HP_NUM_REQ)-1:0]      id;
  } axis_beat_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry register slice: outputs straight from flops, ready registered from fill level.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i
);

  logic [WIDTH-1:0] r_head, r_tail;
  logic [1:0]       r_cnt;
  logic             r_rdy, r_vld;
  logic             w_push, w_pop;
  logic [1:0]       w_cnt_nxt;

  assign w_push    = s_valid_i & r_rdy;
  assign w_pop     = r_vld & m_ready_i;
  assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

  assign s_ready_o = r_rdy;
  assign m_valid_o = r_vld;
  assign m_data_o  = r_head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
      r_vld  <= 1'b0;
      r_rdy  <= 1'b1;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_vld <= (w_cnt_nxt != 2'd0);
      r_rdy <= !w_cnt_nxt[1];
      case (r_cnt)
        2'd0: if (w_push) r_head <= s_data_i;
        2'd1: begin
          if (w_push && w_pop) r_head <= s_data_i;
          else if (w_push)     r_tail <= s_data_i;
        end
        default: if (w_pop) begin
          r_head <= r_tail;
          if (w_push) r_tail <= s_data_i;
        end
      endcase
    end
  end

endmodule

// File: rtl/hash_req_arbiter.sv
// Packet-atomic round-robin arbiter feeding the hash table request input.
module hash_req_arbiter
  import hash_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  parameter  int NUM_REQ    = 4,
  localparam int KEEP_WIDTH = keep_w(DATA_WIDTH),
  localparam int ID_WIDTH   = id_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data_i,
  input  logic [NUM_REQ*KEEP_WIDTH-1:0] s_keep_i,
  input  logic [NUM_REQ-1:0]            s_valid_i,
  input  logic [NUM_REQ-1:0]            s_last_i,
  output logic [NUM_REQ-1:0]            s_ready_o,
  output logic [DATA_WIDTH-1:0]         m_data_o,
  output logic [KEEP_WIDTH-1:0]         m_keep_o,
  output logic                          m_valid_o,
  output logic                          m_last_o,
  output logic [ID_WIDTH-1:0]           m_id_o,
  input  logic                          m_ready_i
);

  localparam int PW = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH;

  arb_state_t            r_state;
  logic [ID_WIDTH-1:0]   r_grant, r_rr_ptr;
  logic [NUM_REQ-1:0]    w_gnt_oh;
  logic [DATA_WIDTH-1:0] w_data;
  logic [KEEP_WIDTH-1:0] w_keep;
  logic                  w_valid, w_last, w_s_vld, w_skid_rdy, w_acc;
  logic [PW-1:0]         w_s_pay, w_m_pay;

  // First requesting index at or after ptr, wrapping modulo NUM_REQ.
  function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                  input logic [ID_WIDTH-1:0] ptr);
    logic found;
    int   idx;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        rr_pick = ID_WIDTH'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    w_data  = '0;
    w_keep  = '0;
    w_valid = 1'b0;
    w_last  = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (r_grant == ID_WIDTH'(r)) begin
        w_data  = s_data_i[r*DATA_WIDTH +: DATA_WIDTH];
        w_keep  = s_keep_i[r*KEEP_WIDTH +: KEEP_WIDTH];
        w_valid = s_valid_i[r];
        w_last  = s_last_i[r];
      end
    end
  end

  assign w_gnt_oh  = (r_state == BUSY) ? (NUM_REQ'(1) << r_grant) : '0;
  assign s_ready_o = w_gnt_oh & {NUM_REQ{w_skid_rdy}};
  assign w_s_vld   = (r_state == BUSY) && w_valid;
  assign w_acc     = w_s_vld && w_skid_rdy;
  assign w_s_pay   = {w_data, w_keep, w_last, r_grant};
  assign {m_data_o, m_keep_o, m_last_o, m_id_o} = w_m_pay;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        IDLE: if (|s_valid_i) begin
          r_grant <= rr_pick(s_valid_i, r_rr_ptr);
          r_state <= BUSY;
        end
        BUSY: if (w_acc && w_last) begin
          r_rr_ptr <= (r_grant == ID_WIDTH'(NUM_REQ-1)) ? '0 : r_grant + 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  axis_skid_buffer #(.WIDTH(PW)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .s_data_i (w_s_pay),
    .s_valid_i(w_s_vld),
    .s_ready_o(w_skid_rdy),
    .m_data_o (w_m_pay),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i)
  );

endmodule

// File: tb/tb_hash_req_arbiter.sv
// Packet table + per-requester sources + expected-beat scoreboard for hash_req_arbiter.
module tb_hash_req_arbiter;

  localparam int DW = 64;
  localparam int NR = 4;
  localparam int KW = 8;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR*DW-1:0] s_data_i;
  logic [NR*KW-1:0] s_keep_i;
  logic [NR-1:0]    s_valid_i, s_last_i, s_ready_o;
  logic [DW-1:0]    m_data_o;
  logic [KW-1:0]    m_keep_o;
  logic             m_valid_o, m_last_o, m_ready_i;
  logic [IW-1:0]    m_id_o;

  always #5 clk = ~clk;

  hash_req_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk(clk), .reset(reset),
    .s_data_i(s_data_i), .s_keep_i(s_keep_i), .s_valid_i(s_valid_i),
    .s_last_i(s_last_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_keep_o(m_keep_o), .m_valid_o(m_valid_o),
    .m_last_o(m_last_o), .m_id_o(m_id_o), .m_ready_i(m_ready_i)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    int            id;
    int            cyc;
  } beat_t;

  typedef struct {
    int            req;
    int            nb;
    logic [DW-1:0] base;
    logic [KW-1:0] keep;
    int            cyc0;
  } pkt_t;

  pkt_t          tbl[10];
  beat_t         src_q[NR][$];
  beat_t         exp_q[$];
  logic [NR-1:0] fire;
  int            n_chk, n_fail, rel, stall_lo, stall_hi;
  logic          chk_en, prev_stall, prev_last;
  logic [DW-1:0] prev_data;
  logic [IW-1:0] prev_id;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load(input pkt_t p);
    beat_t bt;
    for (int b = 0; b < p.nb; b++) begin
      bt.data = p.base + 64'(b);
      bt.keep = p.keep;
      bt.last = (b == p.nb - 1);
      bt.id   = p.req;
      bt.cyc  = (p.cyc0 < 0) ? -1 : p.cyc0 + b;
      src_q[p.req].push_back(bt);
      exp_q.push_back(bt);
    end
  endtask

  // One cycle, evaluated at the falling edge: retire last cycle's handshakes, drive, check.
  task automatic step();
    beat_t e;
    for (int r = 0; r < NR; r++)
      if (fire[r]) void'(src_q[r].pop_front());
    m_ready_i = !(rel >= stall_lo && rel < stall_hi);
    for (int r = 0; r < NR; r++) begin
      if (src_q[r].size() > 0) begin
        s_valid_i[r]         = 1'b1;
        s_data_i[r*DW +: DW] = src_q[r][0].data;
        s_keep_i[r*KW +: KW] = src_q[r][0].keep;
        s_last_i[r]          = src_q[r][0].last;
      end else begin
        s_valid_i[r] = 1'b0;
        s_last_i[r]  = 1'b0;
      end
    end
    fire = s_valid_i & s_ready_o;
    if (chk_en) begin
      chk("ready_onehot", 64'($countones(s_ready_o) <= 1), 64'd1);
      if (rel > stall_lo && rel < stall_hi) chk("ready_drop_stall", 64'(s_ready_o), 64'd0);
      if (prev_stall) begin
        chk("hold_valid", 64'(m_valid_o), 64'd1);
        chk("hold_data", m_data_o, prev_data);
        chk("hold_last_id", {m_last_o, m_id_o}, {prev_last, prev_id});
      end
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) chk("extra_beat", m_data_o, 64'hDEAD);
        else begin
          e = exp_q.pop_front();
          chk("data", m_data_o, e.data);
          chk("keep", 64'(m_keep_o), 64'(e.keep));
          chk("last", 64'(m_last_o), 64'(e.last));
          chk("id", 64'(m_id_o), 64'(e.id));
          if (e.cyc >= 0) chk("latency", 64'(rel), 64'(e.cyc));
        end
      end
    end
    prev_stall = m_valid_o && !m_ready_i;
    prev_data  = m_data_o;
    prev_last  = m_last_o;
    prev_id    = m_id_o;
    @(negedge clk);
    rel++;
  endtask

  task automatic run_phase(input int first, input int n, input int slo, input int shi);
    int pend;
    rel = 0; stall_lo = slo; stall_hi = shi; fire = '0;
    for (int i = 0; i < n; i++) load(tbl[first + i]);
    forever begin
      pend = 0;
      for (int r = 0; r < NR; r++) pend += src_q[r].size();
      if (pend == 0 && exp_q.size() == 0 && !m_valid_o) break;
      if (rel >= 60) begin
        n_chk++; n_fail++;
        $display("FAIL timeout: phase %0d, %0d beats still expected", first, exp_q.size());
        exp_q.delete();
        for (int r = 0; r < NR; r++) src_q[r].delete();
        s_valid_i = '0; fire = '0;
        break;
      end
      step();
    end
    stall_lo = -1; stall_hi = -1; m_ready_i = 1'b1;
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_s_ready"}, 64'(s_ready_o), 64'd0);
    chk({name, "_m_valid_last"}, {m_valid_o, m_last_o}, 64'd0);
    chk({name, "_m_data"}, m_data_o, 64'd0);
    chk({name, "_m_keep_id"}, {m_keep_o, m_id_o}, 64'd0);
  endtask

  initial begin
    int acc;
    // {req, beats, base data, keep, cycle of first beat rel. to load (-1 = unchecked)}
    tbl[0] = '{2, 3, 64'hA0,  8'hFF, 2};   // single requester
    tbl[1] = '{3, 2, 64'h300, 8'h0F, 2};   // wrap: 3 first...
    tbl[2] = '{0, 2, 64'h400, 8'hF0, 5};   // ...then 0
    tbl[3] = '{1, 1, 64'h510, 8'h01, 2};   // single-beat packets
    tbl[4] = '{2, 1, 64'h520, 8'h80, 4};
    tbl[5] = '{1, 4, 64'h600, 8'h3C, -1};  // backpressure
    tbl[6] = '{0, 2, 64'h700, 8'hFF, 2};   // contention after reset
    tbl[7] = '{1, 2, 64'h710, 8'h0F, 5};
    tbl[8] = '{3, 2, 64'h730, 8'hF0, 8};
    tbl[9] = '{0, 2, 64'h740, 8'h55, 11};

    n_chk = 0; n_fail = 0; rel = 0; chk_en = 1'b1; fire = '0;
    stall_lo = -1; stall_hi = -1; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0; prev_id = '0;
    s_data_i = '0; s_keep_i = '0; s_valid_i = '0; s_last_i = '0; m_ready_i = 1'b1;
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    chk_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clk); @(negedge clk);

    run_phase(0, 1, -1, -1);
    chk("rr_ptr_after_single", 64'(dut.r_rr_ptr), 64'd3);
    run_phase(1, 2, -1, -1);
    chk("rr_ptr_after_wrap", 64'(dut.r_rr_ptr), 64'd1);
    run_phase(3, 2, -1, -1);
    chk("rr_ptr_after_single_beat", 64'(dut.r_rr_ptr), 64'd3);
    run_phase(5, 1, 3, 8);
    chk("rr_ptr_after_stall", 64'(dut.r_rr_ptr), 64'd2);

    // Reset after the second of four beats from requester 3.
    chk_en = 1'b0; rel = 0; fire = '0; acc = 0;
    for (int b = 0; b < 4; b++) src_q[3].push_back('{64'h900 + 64'(b), 8'hFF, (b == 3), 3, -1});
    for (int i = 0; i < 20 && acc < 2; i++) begin
      step();
      if (fire[3]) acc++;
    end
    if (acc < 2) begin
      n_chk++; n_fail++;
      $display("FAIL reset_mid_pkt: only %0d beats accepted", acc);
    end
    reset = 1'b1;
    #1;
    chk_outputs_zero("reset_mid_pkt");
    src_q[3].delete(); fire = '0; s_valid_i = '0; s_last_i = '0; prev_stall = 1'b0;
    @(negedge clk);
    chk_outputs_zero("reset_hold");
    reset = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    chk("rr_ptr_after_reset", 64'(dut.r_rr_ptr), 64'd0);

    run_phase(6, 4, -1, -1);
    chk("rr_ptr_after_contention", 64'(dut.r_rr_ptr), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
